viterbi_decoder: RTL and testbench

VITERBI_DECODER -- requirements
Module: viterbi_decoder

---
 rtl/viterbi_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_viterbi_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for K3/K5/K7/K9, rate 1/2 or 1/3, zero-terminated frames.
// One full ACS step per accepted symbol, then an N-cycle traceback and an N-cycle bit replay.
module viterbi_decoder #(
  parameter int MAX_FRAME_LEN         = 64,
  parameter int PM_WIDTH              = 9,
  parameter int MAX_CODE_RATE         = 3,
  parameter int MAX_CONSTRAINT_LENGTH = 9
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    en_vd,
  input  logic                                                    i_code_rate,
  input  logic [1:0]                                              i_constr_len,
  input  logic [MAX_CODE_RATE-1:0][MAX_CONSTRAINT_LENGTH-1:0]     i_gen_poly,
  input  logic [MAX_CODE_RATE-1:0]                                i_rx_data,
  input  logic                                                    i_rx_valid,
  input  logic                                                    i_rx_last,
  output logic                                                    o_ready,
  output logic                                                    o_decoded_bit,
  output logic                                                    o_decoded_valid,
  output logic                                                    o_decoder_done,
  output logic [PM_WIDTH-1:0]                                     o_final_metric,
  output logic [1:0]                                              o_dbg_state
);

  localparam int KMAX  = MAX_CONSTRAINT_LENGTH;
  localparam int SW    = KMAX - 1;
  localparam int S_MAX = 1 << SW;
  localparam int CW    = $clog2(MAX_FRAME_LEN);
  localparam int LW    = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [PM_WIDTH-1:0] PM_INF = PM_WIDTH'(256);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACS = 2'd1, S_TRACEBACK = 2'd2, S_OUTPUT = 2'd3} state_t;

  // Handshake: a symbol is taken on a rising edge where en_vd, i_rx_valid and o_ready are all 1.
  // o_ready is registered from the FSM state alone and never depends on i_rx_valid.

  state_t                r_state;
  logic                  r_ready;
  logic [PM_WIDTH-1:0]   r_pm [S_MAX];
  logic [S_MAX-1:0]      r_surv [MAX_FRAME_LEN];
  logic [MAX_FRAME_LEN-1:0] r_bits;
  logic [LW-1:0]         r_step;
  logic [LW-1:0]         r_len;
  logic [CW-1:0]         r_idx;
  logic [SW-1:0]         r_tb_state;
  logic                  r_dec_bit;
  logic                  r_dec_valid;
  logic                  r_done;
  logic [PM_WIDTH-1:0]   r_final_metric;

  logic [3:0]            w_km1;
  logic [KMAX-1:0]       w_kmask;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_out_last;
  logic [PM_WIDTH-1:0]   w_new_pm [S_MAX];
  logic [S_MAX-1:0]      w_dec;
  logic                  w_surv_bit;
  logic [SW-1:0]         w_tb_next;

  function automatic logic [PM_WIDTH-1:0] pm_init(input int s);
    return (s == 0) ? '0 : PM_INF;
  endfunction

  function automatic logic [1:0] branch_metric(
    input logic [KMAX-1:0]                         win,
    input logic [MAX_CODE_RATE-1:0][KMAX-1:0]      poly,
    input logic [KMAX-1:0]                         kmask,
    input logic [MAX_CODE_RATE-1:0]                rx,
    input logic                                    rate13
  );
    logic [MAX_CODE_RATE-1:0] e;
    for (int i = 0; i < MAX_CODE_RATE; i++) e[i] = (^(win & poly[i] & kmask)) ^ rx[i];
    if (!rate13) e[2] = 1'b0;
    return 2'({1'b0, e[0]} + {1'b0, e[1]} + {1'b0, e[2]});
  endfunction

  assign w_km1      = {1'b0, i_constr_len, 1'b0} + 4'd2;
  assign w_accept   = en_vd & i_rx_valid & r_ready;
  assign w_last     = i_rx_last | (r_step == LW'(MAX_FRAME_LEN - 1));
  assign w_out_last = (LW'(r_idx) == r_len - LW'(1));

  always_comb begin
    w_kmask = '0;
    for (int k = 0; k < KMAX; k++) w_kmask[k] = (k <= int'(w_km1));
  end

  // Window for predecessor p0 is {0, ns}; p1 only differs in window bit K-1.
  always_comb begin : acs
    logic [SW-1:0]       v_ns;
    logic [SW-1:0]       v_p0;
    logic [SW-1:0]       v_p1;
    logic [KMAX-1:0]     v_w0;
    logic [KMAX-1:0]     v_w1;
    logic [PM_WIDTH-1:0] v_m0;
    logic [PM_WIDTH-1:0] v_m1;
    v_ns = '0;
    v_p0 = '0;
    v_p1 = '0;
    v_w0 = '0;
    v_w1 = '0;
    v_m0 = '0;
    v_m1 = '0;
    w_dec = '0;
    for (int ns = 0; ns < S_MAX; ns++) begin
      v_ns = SW'(ns);
      v_p0 = v_ns >> 1;
      v_p1 = v_p0 | (SW'(1) << (w_km1 - 4'd1));
      v_w0 = {1'b0, v_ns};
      v_w1 = v_w0 | (KMAX'(1) << w_km1);
      v_m0 = r_pm[v_p0] + PM_WIDTH'(branch_metric(v_w0, i_gen_poly, w_kmask, i_rx_data, i_code_rate));
      v_m1 = r_pm[v_p1] + PM_WIDTH'(branch_metric(v_w1, i_gen_poly, w_kmask, i_rx_data, i_code_rate));
      if ((ns >> w_km1) != 0) begin
        w_new_pm[v_ns] = r_pm[v_ns];
        w_dec[v_ns]    = 1'b0;
      end else begin
        w_dec[v_ns]    = (v_m1 < v_m0);
        w_new_pm[v_ns] = (v_m1 < v_m0) ? v_m1 : v_m0;
      end
    end
  end

  assign w_surv_bit = r_surv[r_idx][r_tb_state];
  assign w_tb_next  = (r_tb_state >> 1) | (SW'(w_surv_bit) << (w_km1 - 4'd1));

  always_ff @(posedge clk) begin
    if (w_accept) r_surv[r_step[CW-1:0]] <= w_dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_ready        <= 1'b0;
      r_step         <= '0;
      r_len          <= '0;
      r_idx          <= '0;
      r_tb_state     <= '0;
      r_dec_bit      <= 1'b0;
      r_dec_valid    <= 1'b0;
      r_done         <= 1'b0;
      r_final_metric <= '0;
      r_bits         <= '0;
      for (int s = 0; s < S_MAX; s++) r_pm[s] <= pm_init(s);
    end else if (!en_vd) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_step      <= '0;
      r_dec_bit   <= 1'b0;
      r_dec_valid <= 1'b0;
      r_done      <= 1'b0;
      for (int s = 0; s < S_MAX; s++) r_pm[s] <= pm_init(s);
    end else begin
      r_dec_bit   <= 1'b0;
      r_dec_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE, S_ACS: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            for (int s = 0; s < S_MAX; s++) r_pm[s] <= w_new_pm[s];
            r_step <= r_step + LW'(1);
            if (w_last) begin
              r_state        <= S_TRACEBACK;
              r_ready        <= 1'b0;
              r_final_metric <= w_new_pm[0];
              r_len          <= r_step + LW'(1);
              r_idx          <= CW'(r_step);
              r_tb_state     <= '0;
            end else begin
              r_state <= S_ACS;
            end
          end
        end
        S_TRACEBACK: begin
          r_bits[r_idx] <= r_tb_state[0];
          r_tb_state    <= w_tb_next;
          if (r_idx == '0) r_state <= S_OUTPUT;
          else             r_idx   <= r_idx - CW'(1);
        end
        S_OUTPUT: begin
          r_dec_valid <= 1'b1;
          r_dec_bit   <= r_bits[r_idx];
          if (w_out_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_step  <= '0;
            for (int s = 0; s < S_MAX; s++) r_pm[s] <= pm_init(s);
          end else begin
            r_idx <= r_idx + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready         = r_ready;
  assign o_decoded_bit   = r_dec_bit;
  assign o_decoded_valid = r_dec_valid;
  assign o_decoder_done  = r_done;
  assign o_final_metric  = r_final_metric;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Bench for viterbi_decoder: vector table of frames, scoreboard of expected {done, bit} pairs,
// plus hand-written abort and backpressure sequences.
module tb_viterbi_decoder;

  logic            clk;
  logic            rst;
  logic            en_vd;
  logic            i_code_rate;
  logic [1:0]      i_constr_len;
  logic [2:0][8:0] i_gen_poly;
  logic [2:0]      i_rx_data;
  logic            i_rx_valid;
  logic            i_rx_last;
  logic            o_ready;
  logic            o_decoded_bit;
  logic            o_decoded_valid;
  logic            o_decoder_done;
  logic [8:0]      o_final_metric;
  logic [1:0]      o_dbg_state;

  typedef struct packed {
    logic            rate;
    logic [1:0]      k;
    logic [2:0][8:0] poly;
    logic [6:0]      n;
    logic            use_last;
    logic [63:0][2:0] sym;
    logic [63:0]     bits;
    logic [8:0]      metric;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int run = 0;
  int last_run = 0;
  logic [1:0] exp_q[$];
  logic [1:0] e;

  viterbi_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .en_vd          (en_vd),
    .i_code_rate    (i_code_rate),
    .i_constr_len   (i_constr_len),
    .i_gen_poly     (i_gen_poly),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .i_rx_last      (i_rx_last),
    .o_ready        (o_ready),
    .o_decoded_bit  (o_decoded_bit),
    .o_decoded_valid(o_decoded_valid),
    .o_decoder_done (o_decoder_done),
    .o_final_metric (o_final_metric),
    .o_dbg_state    (o_dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rst && !o_ready) run++;
    else if (o_ready && run != 0) begin
      last_run = run;
      run = 0;
    end
    if (o_decoded_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_bit: got bit %0b done %0b, required no output", o_decoded_bit, o_decoder_done);
      end else begin
        e = exp_q.pop_front();
        check("dec_done_bit", {30'b0, o_decoder_done, o_decoded_bit}, {30'b0, e});
      end
    end else if (o_decoder_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_no_valid: got done=1 valid=0, required done only with valid");
    end
    if (o_decoder_done) done_cnt++;
  end

  function automatic logic [63:0][2:0] encode(input logic [63:0] bits, input int n,
                                              input logic [1:0] k, input logic [2:0][8:0] poly,
                                              input bit rate13);
    logic [8:0] sr;
    logic [8:0] win;
    logic [8:0] kmask;
    logic [63:0][2:0] s;
    s = '0;
    sr = '0;
    kmask = 9'((32'd1 << (2 * int'(k) + 3)) - 1);
    for (int t = 0; t < n; t++) begin
      win = {sr[7:0], bits[t]};
      for (int i = 0; i < 3; i++) s[t][i] = ^(win & poly[i] & kmask);
      if (!rate13) s[t][2] = 1'($urandom_range(0, 1));
      sr = win;
    end
    return s;
  endfunction

  function automatic vec_t mk_rand(input logic [1:0] k, input logic [2:0][8:0] poly,
                                   input bit rate13, input int n, input int e0, input int e1);
    vec_t v;
    int kk;
    int ne;
    kk = 2 * int'(k) + 3;
    ne = 0;
    v = '0;
    v.rate = rate13;
    v.k = k;
    v.poly = poly;
    v.n = 7'(n);
    v.use_last = 1'b1;
    for (int t = 0; t < n; t++) v.bits[t] = (t < n - (kk - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
    v.sym = encode(v.bits, n, k, poly, rate13);
    if (e0 >= 0) begin v.sym[e0][0] = ~v.sym[e0][0]; ne++; end
    if (e1 >= 0) begin v.sym[e1][2] = ~v.sym[e1][2]; ne++; end
    v.metric = 9'(ne);
    return v;
  endfunction

  // Driver tasks
  task automatic drive_symbols(input vec_t v, input int count);
    int guard;
    i_code_rate  = v.rate;
    i_constr_len = v.k;
    i_gen_poly   = v.poly;
    for (int i = 0; i < count; i++) begin
      i_rx_data  = v.sym[i];
      i_rx_last  = v.use_last && (i == int'(v.n) - 1);
      i_rx_valid = 1'b1;
      guard = 0;
      while (!o_ready && guard < 400) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!o_ready) begin
        n_cmp++;
        n_err++;
        $display("FAIL ready_timeout: got o_ready=0 for 400 cycles, required 1");
      end
      @(posedge clk); #1;
    end
    i_rx_valid = 1'b0;
    i_rx_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit hold_busy);
    int snap;
    int guard;
    snap = done_cnt;
    for (int i = 0; i < int'(v.n); i++) exp_q.push_back({(i == int'(v.n) - 1), v.bits[i]});
    drive_symbols(v, int'(v.n));
    if (hold_busy) begin
      i_rx_valid = 1'b1;
      guard = 0;
      while (!o_ready && guard < 400) begin
        i_rx_data = 3'($urandom_range(0, 7));
        i_rx_last = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        guard++;
      end
      i_rx_valid = 1'b0;
      i_rx_last  = 1'b0;
    end
    guard = 0;
    while (done_cnt == snap && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done_count", 32'(done_cnt - snap), 32'd1);
    check("final_metric", 32'(o_final_metric), 32'(v.metric));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("ready_low_cycles", 32'(last_run), 32'(2 * int'(v.n)));
    exp_q.delete();
  endtask

  initial begin
    vec_t v;
    int snap;
    rst = 1'b0;
    en_vd = 1'b1;
    i_code_rate = 1'b0;
    i_constr_len = 2'b00;
    i_gen_poly = '0;
    i_rx_data = '0;
    i_rx_valid = 1'b0;
    i_rx_last = 1'b0;

    // Vector table
    v = '0;
    v.poly[0] = 9'o7;
    v.poly[1] = 9'o5;
    v.n = 7'd6;
    v.use_last = 1'b1;
    v.sym[0] = 3'b011; v.sym[1] = 3'b001; v.sym[2] = 3'b000;
    v.sym[3] = 3'b010; v.sym[4] = 3'b010; v.sym[5] = 3'b011;
    v.bits = 64'hD;
    v.metric = 9'd0;
    vecs[0] = v;
    v.sym[2] = 3'b001;
    v.metric = 9'd1;
    vecs[1] = v;
    v.sym = '0;
    v.bits = '0;
    v.n = 7'd64;
    v.use_last = 1'b0;
    v.metric = 9'd0;
    vecs[2] = v;
    v.n = 7'd1;
    v.use_last = 1'b1;
    v.sym[0] = 3'b011;
    v.metric = 9'd2;
    vecs[3] = v;
    vecs[4] = mk_rand(2'b01, {9'o0, 9'o35, 9'o23}, 1'b0, 40, -1, -1);
    vecs[5] = mk_rand(2'b10, {9'o175, 9'o145, 9'o133}, 1'b1, 50, -1, -1);
    vecs[6] = mk_rand(2'b11, {9'o711, 9'o663, 9'o557}, 1'b1, 64, 10, 40);
    vecs[7] = mk_rand(2'b11, {9'o0, 9'o753, 9'o561}, 1'b0, 30, -1, -1);

    // Reset state
    #12;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_decoded_valid), 32'd0);
    check("rst_done", 32'(o_decoder_done), 32'd0);
    check("rst_metric", 32'(o_final_metric), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(o_ready), 32'd1);
    check("idle_after_rst", 32'(o_dbg_state), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], 1'b0);

    // Reset mid-frame, metric from the previous frame must be cleared
    run_vec(vecs[1], 1'b0);
    snap = done_cnt;
    drive_symbols(vecs[0], 3);
    check("metric_held", 32'(o_final_metric), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_rst_ready", 32'(o_ready), 32'd0);
    check("abort_rst_metric", 32'(o_final_metric), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_rst_ready_back", 32'(o_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("abort_rst_no_done", 32'(done_cnt - snap), 32'd0);
    run_vec(vecs[0], 1'b0);

    // Enable dropped mid-frame
    snap = done_cnt;
    drive_symbols(vecs[1], 3);
    en_vd = 1'b0;
    @(posedge clk); #1;
    check("abort_en_state", 32'(o_dbg_state), 32'd0);
    check("abort_en_valid", 32'(o_decoded_valid), 32'd0);
    en_vd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_en_no_done", 32'(done_cnt - snap), 32'd0);
    run_vec(vecs[0], 1'b0);

    // Valid held high while busy, then a normal frame
    run_vec(vecs[1], 1'b1);
    run_vec(vecs[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
